// File: rtl/jmp_label_table_if.sv
// Loader / PC-select bus for the jump-label table.
// The master side is the loader and the fetch PC mux. The slave side is the table.
interface jmp_label_table_if #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 16
);
  logic              load_start;
  logic              load_done;
  logic              wr_valid;
  logic              wr_ready;
  logic [IDX_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hit;
  logic              table_ready;
  logic [IDX_W:0]    entry_count;

  modport master (
    output load_start, load_done, wr_valid, wr_idx, wr_addr, rd_idx,
    input  wr_ready, rd_addr, rd_hit, table_ready, entry_count
  );

  modport slave (
    input  load_start, load_done, wr_valid, wr_idx, wr_addr, rd_idx,
    output wr_ready, rd_addr, rd_hit, table_ready, entry_count
  );
endinterface

// File: rtl/jmp_label_table.sv
// Writable jump-label table: the loader streams (index, target) pairs in during LOAD,
// and the PC-select path reads targets combinationally once the table is READY.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, table not loaded, writes refused, reads miss
// LOAD  | accepting pairs one per cycle, reads miss
// READY | load finished, reads resolve against valid entries
module jmp_label_table #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int ADDR_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  jmp_label_table_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [IDX_W:0]      count_q, count_d;
  logic [ADDR_W-1:0]   data_q [ENTRIES];
  logic                wr_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Data slots are never cleared by load_start; the valid bits hide the stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '{default: '0};
    end else if (wr_commit) begin
      data_q[bus.wr_idx] <= bus.wr_addr;
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    count_d   = count_q;
    wr_commit = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.load_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        wr_commit = bus.wr_valid;
        if (bus.load_done) state_d = S_READY;
      end
      S_READY: begin
        if (bus.load_start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_commit && !valid_q[bus.wr_idx]) begin
      valid_d[bus.wr_idx] = 1'b1;
      count_d             = count_q + 1'b1;
    end

    // A new load overrides everything else on the same edge, including a pending write.
    if (bus.load_start) begin
      state_d   = S_LOAD;
      valid_d   = '0;
      count_d   = '0;
      wr_commit = 1'b0;
    end
  end

  always_comb begin
    bus.wr_ready    = (state_q == S_LOAD);
    bus.table_ready = (state_q == S_READY);
    bus.entry_count = count_q;
    bus.rd_hit      = (state_q == S_READY) && valid_q[bus.rd_idx];
    bus.rd_addr     = bus.rd_hit ? data_q[bus.rd_idx] : '0;
  end

endmodule

// File: doc/jmp_label_table.md
# jmp_label_table

Writable jump-label table for the pipelined core: a loader streams (label index, target address) pairs in over a valid/ready handshake, and the PC-select path reads the resolved jump target by label index in the same cycle. This replaces hard-wired label constants, so a new program's labels are installed at load time without re-synthesis. A small load FSM gates when the table accepts writes and when reads are declared valid. The block sits between the program loader and the fetch-stage PC mux.

## Interface
Parameters:
- ENTRIES, 16, number of label slots
- IDX_W, 4, label index width (log2 ENTRIES)
- ADDR_W, 16, jump target address width

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  pulse: begin a new load, invalidate all entries
- load_done  in  1  pulse: end of load, table becomes readable
- wr_valid  in  1  loader has a pair on wr_idx/wr_addr
- wr_ready  out  1  table accepts a pair this cycle
- wr_idx  in  IDX_W  label slot to write
- wr_addr  in  ADDR_W  target address for that label
- rd_idx  in  IDX_W  label index from the decoded instruction
- rd_addr  out  ADDR_W  jump target for rd_idx
- rd_hit  out  1  rd_addr is a valid, loaded label
- table_ready  out  1  FSM in READY
- entry_count  out  IDX_W+1  number of distinct valid entries, 0..ENTRIES

## Operation
- Storage: ENTRIES x ADDR_W data registers plus one valid bit per entry.
- FSM states: IDLE, LOAD, READY.
  - IDLE: wr_ready=0; load_start -> LOAD; load_done ignored.
  - LOAD: wr_ready=1; every cycle with wr_valid&&wr_ready writes data[wr_idx]=wr_addr, sets valid[wr_idx]; load_done -> READY.
  - READY: wr_ready=0; load_start -> LOAD.
- load_start (any state, including LOAD): clears all valid bits and entry_count on the same edge; data registers keep stale contents but are unreachable.
- load_start and load_done asserted together: load_start wins, next state LOAD.
- Write and load_done in the same LOAD cycle: the write is committed, then state READY.
- Write and load_start in the same LOAD cycle: clear wins, the write is dropped.
- Overwrite of an already-valid index: data replaced, entry_count unchanged. Write to a new index: entry_count +1. entry_count never exceeds ENTRIES.
- Read port is combinational: rd_hit = (state==READY) && valid[rd_idx]; rd_addr = rd_hit ? data[rd_idx] : 0.
- Reset (asserted at any time, including mid-load): state IDLE, all valid bits 0, data 0, entry_count 0, wr_ready 0, table_ready 0, rd_hit 0, rd_addr 0.

## Timing
- Write latency: a pair accepted at edge N is readable from edge N onward, once in READY. There is no write-to-read bypass within a cycle.
- Read latency: zero cycles, from rd_idx to rd_addr/rd_hit, in the same cycle.
- table_ready rises the cycle after the load_done edge and falls the cycle after the load_start edge.
- wr_ready is a registered-state decode only and does not depend on wr_valid.
- The loader must hold wr_idx/wr_addr stable while wr_valid=1 and wr_ready=0.
- Throughput in LOAD: one pair per cycle.

## Test plan
- Reset then idle: hold rst_n=0, release; drive wr_valid=1, rd_idx=3 -> wr_ready=0, rd_hit=0, rd_addr=0, entry_count=0 for 10 cycles.
- Basic load: load_start; write (6,8), (7,39), (11,60) back-to-back; load_done -> table_ready=1; rd_idx=7 gives rd_addr=39, rd_hit=1; rd_idx=5 gives rd_hit=0, rd_addr=0; entry_count=3.
- Overwrite and full table: load all 16 indices with addr=idx*10, then rewrite idx 2 with 999 -> entry_count=16, rd_idx=2 gives 999, rd_idx=15 gives 150.
- Simultaneous events: write (4,196) in the same cycle as load_done -> READY, rd_idx=4 gives 196; in a new load, write (1,22) together with load_start -> entry_count=0 and rd_idx=1 misses after load_done.
- Reload from READY: after a valid table, pulse load_start -> table_ready=0 and rd_hit=0 next cycle; load only (9,46), load_done -> rd_idx=7 misses, rd_idx=9 gives 46.
- Async reset mid-load: after 2 writes in LOAD, drop rst_n between clock edges -> outputs reach reset values immediately; after release, state is IDLE and entry_count=0.
